// File: rtl/factorial_seq_ctrl.sv
// Multi-cycle factorial sequencer: one multiply per clock between two valid/ready handshakes.
// Optional FACT_OVF_EN builds the full-width product and a sticky overflow flag.
module factorial_seq_ctrl #(
  parameter int N     = 4,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] factorial,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [N-1:0]     n_q, n_d;
  logic [OUT_W-1:0] prod;

`ifdef FACT_OVF_EN
  logic [OUT_W+N-1:0] prod_full;
  logic               ovf_q, ovf_d;

  assign prod_full = {{N{1'b0}}, acc_q} * {{OUT_W{1'b0}}, idx_q};
  assign prod      = prod_full[OUT_W-1:0];
`else
  assign prod = acc_q * {{(OUT_W-N){1'b0}}, idx_q};
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    n_d     = n_q;
`ifdef FACT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d     = number;
          acc_d   = {{(OUT_W-1){1'b0}}, 1'b1};
          idx_d   = N'(2);
`ifdef FACT_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = (number <= N'(1)) ? DONE : CALC;
        end
      end
      CALC: begin
        acc_d = prod;
`ifdef FACT_OVF_EN
        ovf_d = ovf_q | (|prod_full[OUT_W+N-1:OUT_W]);
`endif
        // Hold idx on the last multiply so it never wraps when n_q is all ones.
        if (idx_q == n_q) state_d = DONE;
        else              idx_d   = idx_q + N'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= {{(OUT_W-1){1'b0}}, 1'b1};
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

`ifdef FACT_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign overflow = (state_q == DONE) & ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) | (state_q == DONE);
  assign factorial = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Scoreboard bench for factorial_seq_ctrl: expected results queued at accept, checked at result handshake.
module tb_factorial_seq_ctrl;
  localparam int N     = 4;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     number;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] factorial;
  logic             overflow;
  logic             busy;

  factorial_seq_ctrl #(.N(N), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .number   (number),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .factorial(factorial),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] fact;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: factorial mod 2^32, overflow if the true value exceeds 32 bits.
  function automatic exp_t model(input int n);
    exp_t        e;
    logic [63:0] full;
    e.n    = n;
    e.fact = 32'd1;
    e.ovf  = 1'b0;
    for (int i = 2; i <= n; i++) begin
      full = {32'd0, e.fact} * 64'(i);
      if (full[63:32] != 32'd0) e.ovf = 1'b1;
      e.fact = full[31:0];
    end
`ifndef FACT_OVF_EN
    e.ovf = 1'b0;
`endif
    e.lat = (n <= 1) ? 1 : n;
    return e;
  endfunction

  // One operation: accept, wait for result, optionally stall, then handshake.
  task automatic run_op(input int n, input int hold, input bit keep_valid);
    exp_t             e;
    int               lat;
    logic [OUT_W-1:0] held_f;
    logic             held_o;
    @(negedge clk);
    chk($sformatf("in_ready_pre_n%0d", n), in_ready, 1);
    in_valid = 1'b1;
    number   = N'(n);
    sb_q.push_back(model(n));
    @(posedge clk);
    #1;
    if (keep_valid) number = N'(7);
    else            in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk($sformatf("busy_calc_n%0d", n), busy, 1);
      chk($sformatf("in_ready_calc_n%0d", n), in_ready, 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk($sformatf("out_valid_seen_n%0d", n), out_valid, 1);
    e = sb_q.pop_front();
    chk($sformatf("latency_n%0d", n), lat, e.lat);
    held_f = factorial;
    held_o = overflow;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_n%0d", n), out_valid, 1);
      chk($sformatf("hold_fact_n%0d", n), factorial, held_f);
      chk($sformatf("hold_ovf_n%0d", n), overflow, held_o);
    end
    chk($sformatf("factorial_n%0d", n), factorial, e.fact);
    chk($sformatf("overflow_n%0d", n), overflow, e.ovf);
    chk($sformatf("busy_done_n%0d", n), busy, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk($sformatf("idle_out_valid_n%0d", n), out_valid, 0);
    chk($sformatf("idle_in_ready_n%0d", n), in_ready, 1);
    chk($sformatf("idle_busy_n%0d", n), busy, 0);
    chk($sformatf("idle_ovf_n%0d", n), overflow, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    number    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_factorial", factorial, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(0, 0, 0);
    run_op(1, 0, 0);
    run_op(5, 0, 0);
    run_op(12, 10, 0);
    run_op(13, 0, 0);
    run_op(3, 0, 0);
    run_op(15, 2, 0);
    run_op(2, 0, 0);
    run_op(6, 0, 1);
    run_op(4, 0, 0);

    // Abort n=10 mid-calculation: no result may appear.
    @(negedge clk);
    in_valid = 1'b1;
    number   = N'(10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_factorial", factorial, 0);
    chk("abort_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_stray_valid", out_valid, 0);
    end
    run_op(4, 1, 0);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
